// File: rtl/hello_stream.sv
// Purpose: parametrised ASCII message source on a valid/ready byte stream, with start delay, inter-message gaps and repeat count.
// Latency: first byte valid after START_DELAY+1 en-high edges; one byte per cycle while ready; GAP idle cycles between messages.
// Backpressure: tx_valid/tx_data/tx_last hold while tx_ready is low; valid is never withdrawn mid-message.
module hello_stream #(
    parameter int                   MSG_LEN     = 13,
    parameter logic [8*MSG_LEN-1:0] MSG         = "hello world!\n",
    parameter int                   START_DELAY = 10,
    parameter int                   GAP         = 100,
    parameter int                   REPEAT      = 1,
    parameter int                   CNT_W       = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    output logic [7:0]       o_tx_data,
    output logic             o_tx_valid,
    input  logic             i_tx_ready,
    output logic             o_tx_last,
    output logic             o_busy,
    output logic             o_done,
    output logic [CNT_W-1:0] o_msg_cnt
);

    // Index width is at least one bit so a single-byte message still has a legal index register.
    localparam int IDX_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam int ROM_D = 1 << IDX_W;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(MSG_LEN - 1);
    localparam logic [CNT_W-1:0] START_END = CNT_W'(START_DELAY);
    // The edge that moves SEND into GAP already accounts for one idle cycle,
    // so the gap counter terminates one count earlier than the start counter.
    localparam logic [CNT_W-1:0] GAP_END   = (GAP > 0) ? CNT_W'(GAP - 1) : '0;
    localparam logic [CNT_W-1:0] REPEAT_C  = CNT_W'(REPEAT);

    typedef enum logic [1:0] {
        S_START = 2'd0,
        S_SEND  = 2'd1,
        S_GAP   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_dly_cnt;
    logic [IDX_W-1:0] r_idx;
    logic [7:0]       r_tx_data;
    logic             r_tx_valid;
    logic             r_tx_last;
    logic             r_busy;
    logic             r_done;
    logic [CNT_W-1:0] r_msg_cnt;

    logic [7:0]       w_rom [ROM_D];
    logic [IDX_W-1:0] w_idx_inc;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0] w_dly_end;
    logic             w_dly_hit;
    logic             w_xfer;

    // Message bytes unpacked MSB-first; unused tail entries of the power-of-two table read as zero.
    genvar gi;
    generate
        for (gi = 0; gi < ROM_D; gi++) begin : g_rom
            if (gi < MSG_LEN) begin : g_byte
                assign w_rom[gi] = MSG[8*(MSG_LEN-gi)-1 -: 8];
            end else begin : g_pad
                assign w_rom[gi] = 8'h00;
            end
        end
    endgenerate

    assign w_idx_inc = r_idx + 1'b1;
    assign w_cnt_inc = (&r_msg_cnt) ? r_msg_cnt : r_msg_cnt + 1'b1;
    assign w_dly_end = (r_state == S_START) ? START_END : GAP_END;
    assign w_dly_hit = (r_dly_cnt == w_dly_end);
    assign w_xfer    = r_tx_valid & i_tx_ready;

    // Sequencer: delay/gap counting, byte stepping on handshake, repeat accounting, all outputs registered.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_START;
            r_dly_cnt  <= '0;
            r_idx      <= '0;
            r_tx_data  <= 8'h00;
            r_tx_valid <= 1'b0;
            r_tx_last  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_msg_cnt  <= '0;
        end else begin
            case (r_state)
                S_START, S_GAP: begin
                    // Counting only advances on en-high edges; en low freezes the count.
                    if (i_en) begin
                        if (w_dly_hit) begin
                            r_state    <= S_SEND;
                            r_dly_cnt  <= '0;
                            r_idx      <= '0;
                            r_tx_valid <= 1'b1;
                            r_tx_data  <= w_rom[0];
                            r_tx_last  <= (MSG_LEN == 1);
                            r_busy     <= 1'b1;
                        end else begin
                            r_dly_cnt  <= r_dly_cnt + 1'b1;
                        end
                    end
                end

                S_SEND: begin
                    // en is deliberately ignored here so a started message always completes.
                    if (w_xfer) begin
                        if (r_idx != LAST_IDX) begin
                            r_idx     <= w_idx_inc;
                            r_tx_data <= w_rom[w_idx_inc];
                            r_tx_last <= (w_idx_inc == LAST_IDX);
                        end else begin
                            r_msg_cnt <= w_cnt_inc;
                            r_idx     <= '0;
                            if ((REPEAT != 0) && (w_cnt_inc == REPEAT_C)) begin
                                r_state    <= S_DONE;
                                r_tx_valid <= 1'b0;
                                r_tx_last  <= 1'b0;
                                r_busy     <= 1'b0;
                                r_done     <= 1'b1;
                            end else if (GAP == 0) begin
                                // Back-to-back: restart at byte 0 with no valid bubble.
                                r_tx_data <= w_rom[0];
                                r_tx_last <= (MSG_LEN == 1);
                            end else begin
                                r_state    <= S_GAP;
                                r_dly_cnt  <= '0;
                                r_tx_valid <= 1'b0;
                                r_tx_last  <= 1'b0;
                            end
                        end
                    end
                end

                default: begin
                    // DONE is terminal until reset.
                    r_tx_valid <= 1'b0;
                    r_tx_last  <= 1'b0;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b1;
                end
            endcase
        end
    end

    assign o_tx_data  = r_tx_data;
    assign o_tx_valid = r_tx_valid;
    assign o_tx_last  = r_tx_last;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_msg_cnt  = r_msg_cnt;

endmodule

// File: doc/hello_stream.md
Name: hello_stream

Overview:
- Synthesizable, parametrised message generator: after a start delay, emits a fixed ASCII message byte-by-byte on a valid/ready stream, repeats it a configurable number of times with idle gaps, then flags done.
- Used as a bring-up/smoke-test source feeding UART/FIFO/debug sinks, and as a DUT for bench-flow checks.

Parameters:
- MSG_LEN, 13, message length in bytes (>=1)
- MSG, "hello world!\n", message packed MSB-first: byte i = MSG[8*(MSG_LEN-i)-1 -: 8]
- START_DELAY, 10, en-high cycles counted before the first message
- GAP, 100, en-high idle cycles between messages (0 = back-to-back)
- REPEAT, 1, messages to send (0 = forever)
- CNT_W, 16, width of delay/gap counters and msg_cnt; REPEAT < 2^CNT_W, START_DELAY/GAP < 2^CNT_W

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- en  in  1  run enable; pauses START/GAP counting when low
- tx_data  out  8  current byte
- tx_valid  out  1  byte valid
- tx_ready  in  1  sink ready; transfer = tx_valid & tx_ready on rising clk
- tx_last  out  1  high with the final byte of each message
- busy  out  1  high in SEND or GAP
- done  out  1  sticky completion flag
- msg_cnt  out  CNT_W  completed messages, saturating

Behaviour:
- All outputs registered. Reset (rst sampled high): state=START, dly_cnt=0, idx=0, tx_valid=0, tx_data=0, tx_last=0, busy=0, done=0, msg_cnt=0. rst dominates every other input.
- States: START, SEND, GAP, DONE.
- START: on each edge with en=1: if dly_cnt==START_DELAY -> SEND (dly_cnt=0, idx=0, tx_valid=1, tx_data=byte 0), else dly_cnt++. en=0 holds dly_cnt. First tx_valid is high after the (START_DELAY+1)th en-high edge; START_DELAY=0 -> valid after the first en-high edge.
- SEND: tx_valid=1, tx_data=byte idx, tx_last=(idx==MSG_LEN-1). While tx_ready=0, tx_valid/tx_data/tx_last hold stable; valid is never withdrawn. On transfer:
  - idx<MSG_LEN-1: idx++, next byte presented next cycle (one byte per cycle at ready=1).
  - idx==MSG_LEN-1: msg_cnt++ (saturate at all-ones), idx=0; then if REPEAT!=0 and new msg_cnt==REPEAT -> DONE; else if GAP==0 -> stay SEND with byte 0 next cycle (no bubble); else -> GAP, tx_valid=0.
- en is ignored in SEND: a started message always completes.
- GAP: tx_valid=0; counts en-high edges exactly as START, against GAP; after GAP idle cycles (en=1 throughout), byte 0 is valid in the following cycle.
- DONE: tx_valid=0, tx_last=0, busy=0, done=1; held until rst.
- MSG_LEN=1: every byte has tx_last=1.
- Reset mid-message: the cycle after rst is sampled high, tx_valid=0 and msg_cnt=0; after release the sequence restarts from START with the full delay and byte 0.

Test Plan:
- Defaults, en=1 and tx_ready=1 from reset release -> first tx_valid after the 11th edge; 13 consecutive bytes 0x68 0x65 0x6C 0x6C 0x6F 0x20 0x77 0x6F 0x72 0x6C 0x64 0x21 0x0A; tx_last only on 0x0A; done=1 and msg_cnt=1 the next cycle; tx_valid stays 0 afterwards.
- Defaults, tx_ready pseudo-random 50% -> identical byte sequence; tx_data/tx_last stable every cycle with valid=1 and ready=0; exactly 13 transfers.
- REPEAT=3, GAP=5, ready=1 -> exactly 5 valid-low cycles between each 0x0A and the next 0x68; 39 transfers; done=1 with msg_cnt=3.
- REPEAT=2, GAP=0, ready=1 -> 26 transfers on 26 consecutive cycles with no valid bubble; busy=1 throughout; done after the second 0x0A.
- en low for 4 cycles during START -> first valid delayed by exactly 4 cycles. en dropped during byte 3 of SEND -> the message completes to 0x0A; GAP counting pauses until en returns.
- rst pulsed 1 cycle when idx=5 (REPEAT=3, one message already sent) -> next cycle tx_valid=0, msg_cnt=0, done=0; after the 11-edge start delay, transfer restarts from 0x68.
